// File: rtl/mb_calc_pkg.sv
// Shared encodings and defaults for the floating-point request arbiter.
// The arithmetic units are external; only their interface codes live here.
package mb_calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALIGN = 2'b01,
    ST_RUN   = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam int unsigned LATENCY_DEF = 58;

  // True when the first biased exponent is strictly smaller than the second.
  function automatic logic exp_less(input logic [7:0] ea, input logic [7:0] eb);
    return (ea < eb);
  endfunction

endpackage

// File: rtl/mb_alu_arbiter_chk.sv
// Protocol checker: exclusive grants, frozen operands in RUN, one response per grant.
module mb_alu_arbiter_chk (
  input logic        CLK_1MHz,
  input logic        RSTN,
  input logic        gnt0,
  input logic        gnt1,
  input logic        rsp_valid,
  input logic [5:0]  dp_cnt,
  input logic [31:0] dp_a,
  input logic [31:0] dp_b
);

  logic pending_r;

  // Tracks a granted operation that has not yet produced its response.
  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      pending_r <= 1'b0;
    end else if (gnt0 || gnt1) begin
      pending_r <= 1'b1;
    end else if (rsp_valid) begin
      pending_r <= 1'b0;
    end
  end

  a_one_gnt: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    !(gnt0 && gnt1));

  a_run_stable: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    (dp_cnt > 6'd1) |-> ($stable(dp_a) && $stable(dp_b)));

  a_resp_stable: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    rsp_valid |-> ($stable(dp_a) && $stable(dp_b)));

  a_rsp_pulse: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    rsp_valid |=> !rsp_valid);

  a_rsp_owned: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    rsp_valid |-> pending_r);

  a_gnt_free: assert property (@(posedge CLK_1MHz) disable iff (!RSTN)
    (gnt0 || gnt1) |-> !pending_r);

endmodule

// File: rtl/mb_rr_arb2.sv
// Two-way round-robin selector; the pointer remembers the last granted requester.
module mb_rr_arb2 (
  input  logic       CLK_1MHz,
  input  logic       RSTN,
  input  logic [1:0] req,
  input  logic       take,
  output logic       winner
);

  logic last_r;
  logic winner_s;

  // Winner selection: a tie goes to whoever was not granted last.
  always_comb begin
    winner_s = 1'b0;
    if (req[0] && req[1]) begin
      winner_s = ~last_r;
    end else if (req[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Last-grant pointer; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      last_r <= 1'b1;
    end else if (take) begin
      last_r <= winner_s;
    end
  end

  assign winner = winner_s;

endmodule

// File: rtl/mb_alu_arbiter.sv
// Arbitrates two requesters onto one shared FP add/sub, mul and div datapath,
// aligning add/sub operands and sampling the selected result after LATENCY cycles.
module mb_alu_arbiter
  import mb_calc_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic        CLK_1MHz,
  input  logic        RSTN,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [5:0]  dp_cnt,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  input  logic        ovf_as,
  input  logic        ovf_mul,
  input  logic        ovf_div,
  input  logic        dz,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_dv_by_zero,
  output logic        busy
);

  localparam logic [5:0] LAT_C = 6'(LATENCY);

  state_e      state_r, state_s;
  op_e         op_r, lat_op_s;
  logic        id_r;
  logic [5:0]  dp_cnt_r;
  logic [31:0] dp_a_r, dp_b_r, rsp_result_r;
  logic        gnt0_r, gnt1_r, rsp_valid_r, rsp_id_r;
  logic        rsp_overflow_r, rsp_dv_by_zero_r, busy_r;
  logic        accept_s, winner_s, swap_s, run_done_s;
  logic [31:0] lat_a_s, raw_b_s, lat_b_s;
  logic [31:0] cap_res_s;
  logic        cap_ovf_s, cap_dz_s;

  assign accept_s   = (state_r == ST_IDLE) && (req0 || req1);
  assign run_done_s = (state_r == ST_RUN) && (dp_cnt_r == LAT_C);
  assign swap_s     = ((op_r == OP_ADD) || (op_r == OP_SUB)) &&
                      exp_less(dp_a_r[30:23], dp_b_r[30:23]);

  mb_rr_arb2 u_arb (
    .CLK_1MHz (CLK_1MHz),
    .RSTN     (RSTN),
    .req      ({req1, req0}),
    .take     (accept_s),
    .winner   (winner_s)
  );

  // Operands of the winning requester; subtraction becomes addition of -b.
  always_comb begin
    lat_op_s = winner_s ? op_e'(op1) : op_e'(op0);
    lat_a_s  = winner_s ? a1 : a0;
    raw_b_s  = winner_s ? b1 : b0;
    lat_b_s  = (lat_op_s == OP_SUB) ? {~raw_b_s[31], raw_b_s[30:0]} : raw_b_s;
  end

  // Result and flag selection from the shared units according to the latched op.
  always_comb begin
    cap_res_s = add_res;
    cap_ovf_s = ovf_as;
    cap_dz_s  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        cap_res_s = add_res;
        cap_ovf_s = ovf_as;
      end
      OP_MUL: begin
        cap_res_s = mul_res;
        cap_ovf_s = ovf_mul;
      end
      OP_DIV: begin
        cap_res_s = div_res;
        cap_ovf_s = ovf_div;
        cap_dz_s  = dz;
      end
      default: begin
        cap_res_s = add_res;
        cap_ovf_s = ovf_as;
      end
    endcase
  end

  // Next-state logic; RESP always falls back to IDLE so no accept happens there.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = accept_s ? ST_ALIGN : ST_IDLE;
      ST_ALIGN: state_s = ST_RUN;
      ST_RUN:   state_s = run_done_s ? ST_RESP : ST_RUN;
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshakes, datapath operands, sequence count and response.
  always_ff @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      op_r             <= OP_ADD;
      id_r             <= 1'b0;
      gnt0_r           <= 1'b0;
      gnt1_r           <= 1'b0;
      busy_r           <= 1'b0;
      dp_cnt_r         <= 6'd0;
      dp_a_r           <= 32'd0;
      dp_b_r           <= 32'd0;
      rsp_valid_r      <= 1'b0;
      rsp_id_r         <= 1'b0;
      rsp_result_r     <= 32'd0;
      rsp_overflow_r   <= 1'b0;
      rsp_dv_by_zero_r <= 1'b0;
    end else begin
      gnt0_r      <= accept_s && !winner_s;
      gnt1_r      <= accept_s && winner_s;
      busy_r      <= (state_s != ST_IDLE);
      rsp_valid_r <= run_done_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r   <= lat_op_s;
            id_r   <= winner_s;
            dp_a_r <= lat_a_s;
            dp_b_r <= lat_b_s;
          end
        end
        ST_ALIGN: begin
          if (swap_s) begin
            dp_a_r <= dp_b_r;
            dp_b_r <= dp_a_r;
          end
          dp_cnt_r <= 6'd1;
        end
        ST_RUN: begin
          if (run_done_s) begin
            dp_cnt_r         <= 6'd0;
            rsp_id_r         <= id_r;
            rsp_result_r     <= cap_res_s;
            rsp_overflow_r   <= cap_ovf_s;
            rsp_dv_by_zero_r <= cap_dz_s;
          end else begin
            dp_cnt_r <= dp_cnt_r + 6'd1;
          end
        end
        ST_RESP: begin
          dp_cnt_r <= 6'd0;
        end
        default: begin
          dp_cnt_r <= 6'd0;
        end
      endcase
    end
  end

  assign gnt0           = gnt0_r;
  assign gnt1           = gnt1_r;
  assign busy           = busy_r;
  assign dp_cnt         = dp_cnt_r;
  assign dp_a           = dp_a_r;
  assign dp_b           = dp_b_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_id         = rsp_id_r;
  assign rsp_result     = rsp_result_r;
  assign rsp_overflow   = rsp_overflow_r;
  assign rsp_dv_by_zero = rsp_dv_by_zero_r;

  mb_alu_arbiter_chk u_chk (
    .CLK_1MHz  (CLK_1MHz),
    .RSTN      (RSTN),
    .gnt0      (gnt0_r),
    .gnt1      (gnt1_r),
    .rsp_valid (rsp_valid_r),
    .dp_cnt    (dp_cnt_r),
    .dp_a      (dp_a_r),
    .dp_b      (dp_b_r)
  );

endmodule

// File: tb/tb_mb_alu_arbiter.sv
// Bench for mb_alu_arbiter: a transaction-age model checked every cycle,
// plus directed operations with hand-computed operands and results.
module tb_mb_alu_arbiter;

  localparam int L = 58;

  logic        CLK_1MHz = 1'b0;
  logic        RSTN = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = 2'b00, op1 = 2'b00;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic [31:0] add_res = 32'd0, mul_res = 32'd0, div_res = 32'd0;
  logic        ovf_as = 1'b0, ovf_mul = 1'b0, ovf_div = 1'b0, dz = 1'b0;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_overflow, rsp_dv_by_zero, busy;
  logic [5:0]  dp_cnt;
  logic [31:0] dp_a, dp_b, rsp_result;

  int checks = 0;
  int errors = 0;

  mb_alu_arbiter dut (
    .CLK_1MHz(CLK_1MHz), .RSTN(RSTN),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .dp_cnt(dp_cnt), .dp_a(dp_a), .dp_b(dp_b),
    .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
    .ovf_as(ovf_as), .ovf_mul(ovf_mul), .ovf_div(ovf_div), .dz(dz),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_dv_by_zero(rsp_dv_by_zero), .busy(busy)
  );

  always #5 CLK_1MHz = ~CLK_1MHz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_age counts edges since the accept edge (-1 = no operation).
  int          m_age = -1;
  logic        m_ptr = 1'b1, m_id = 1'b0;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
  logic        m_ovf = 1'b0, m_dz = 1'b0, m_rid = 1'b0;
  logic        n_w;
  logic [1:0]  n_op;
  logic [31:0] n_a, n_b, n_bs, n_fa, n_fb, c_res;
  logic        c_ovf, c_dz;

  always_comb begin
    n_w  = (req0 && req1) ? ~m_ptr : req1;
    n_op = n_w ? op1 : op0;
    n_a  = n_w ? a1 : a0;
    n_bs = n_w ? b1 : b0;
    n_b  = (n_op == 2'b01) ? (n_bs ^ 32'h8000_0000) : n_bs;
    if (n_op[1] == 1'b0 && n_a[30:23] < n_b[30:23]) begin
      n_fa = n_b;
      n_fb = n_a;
    end else begin
      n_fa = n_a;
      n_fb = n_b;
    end
    c_res = (m_op == 2'b10) ? mul_res : (m_op == 2'b11) ? div_res : add_res;
    c_ovf = (m_op == 2'b10) ? ovf_mul : (m_op == 2'b11) ? ovf_div : ovf_as;
    c_dz  = (m_op == 2'b11) ? dz : 1'b0;
  end

  always @(posedge CLK_1MHz or negedge RSTN) begin
    if (!RSTN) begin
      m_age <= -1; m_ptr <= 1'b1; m_a <= 32'd0; m_b <= 32'd0;
      m_res <= 32'd0; m_ovf <= 1'b0; m_dz <= 1'b0; m_rid <= 1'b0;
    end else if (m_age < 0) begin
      if (req0 || req1) begin
        m_age <= 0; m_ptr <= n_w; m_id <= n_w; m_op <= n_op;
        m_a <= n_fa; m_b <= n_fb;
      end
    end else if (m_age == L + 1) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age == L) begin
        m_res <= c_res; m_ovf <= c_ovf; m_dz <= c_dz; m_rid <= m_id;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK_1MHz) begin
    chk("gnt0", {31'd0, gnt0}, {31'd0, (m_age == 0) && !m_id});
    chk("gnt1", {31'd0, gnt1}, {31'd0, (m_age == 0) && m_id});
    chk("busy", {31'd0, busy}, {31'd0, m_age >= 0});
    chk("dp_cnt", {26'd0, dp_cnt}, (m_age >= 1 && m_age <= L) ? m_age : 0);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_age == L + 1});
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_rid});
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, m_ovf});
    chk("rsp_dv_by_zero", {31'd0, rsp_dv_by_zero}, {31'd0, m_dz});
    if (m_age != 0) begin
      chk("dp_a", dp_a, m_a);
      chk("dp_b", dp_b, m_b);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
    chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    chk({tag, "_rsp_ovf"}, {31'd0, rsp_overflow}, 32'd0);
    chk({tag, "_rsp_dz"}, {31'd0, rsp_dv_by_zero}, 32'd0);
    chk({tag, "_dp_cnt"}, {26'd0, dp_cnt}, 32'd0);
    chk({tag, "_dp_a"}, dp_a, 32'd0);
    chk({tag, "_dp_b"}, dp_b, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
  endtask

  task automatic start_req(input bit id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ra, input logic [31:0] rm, input logic [31:0] rd,
                           input logic [3:0] flags);
    @(negedge CLK_1MHz);
    add_res = ra; mul_res = rm; div_res = rd;
    {ovf_as, ovf_mul, ovf_div, dz} = flags;
    if (id) begin
      op1 = op; a1 = a; b1 = b; req1 = 1'b1;
    end else begin
      op0 = op; a0 = a; b0 = b; req0 = 1'b1;
    end
  endtask

  // One request; latency is counted in edges after the accept edge (L+1,
  // i.e. L+2 edges including the accept edge itself).
  task automatic do_op(input string nm, input bit id, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ra, input logic [31:0] rm, input logic [31:0] rd,
                       input logic [3:0] flags, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] er, input bit eovf, input bit edz, input bit poke);
    int k;
    start_req(id, op, a, b, ra, rm, rd, flags);
    k = 0;
    do begin @(negedge CLK_1MHz); k++; end while (!(gnt0 || gnt1) && k < 8);
    chk({nm, "_gnt"}, {31'd0, id ? gnt1 : gnt0}, 32'd1);
    chk({nm, "_gnt_delay"}, k, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    k = 0;
    do begin
      @(negedge CLK_1MHz); k++;
      if (k == 1) begin
        chk({nm, "_dp_a"}, dp_a, ea);
        chk({nm, "_dp_b"}, dp_b, eb);
      end
      if (poke && k == 10) begin
        if (id) req0 = 1'b1; else req1 = 1'b1;
      end
      if (poke && k == 20) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end while (!rsp_valid && k < L + 10);
    chk({nm, "_latency"}, k, L + 1);
    chk({nm, "_result"}, rsp_result, er);
    chk({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({nm, "_ovf"}, {31'd0, rsp_overflow}, {31'd0, eovf});
    chk({nm, "_dz"}, {31'd0, rsp_dv_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int k;
    int n;
    int cnt;
    int g [3];
    #1 RSTN = 1'b0;
    repeat (3) @(negedge CLK_1MHz);
    check_reset_vals("reset");
    RSTN = 1'b1;

    // Add 1.5 + 2.25: exponents 127 < 128, operands swap.
    do_op("add", 1'b0, 2'b00, 32'h3FC0_0000, 32'h4010_0000,
          32'h4070_0000, 32'h1111_1111, 32'h2222_2222, 4'b0000,
          32'h4010_0000, 32'h3FC0_0000, 32'h4070_0000, 1'b0, 1'b0, 1'b0);
    // Sub 1.0 - 3.0: b becomes -3.0 and swaps ahead; overflow from add/sub unit.
    do_op("sub", 1'b1, 2'b01, 32'h3F80_0000, 32'h4040_0000,
          32'hC000_0000, 32'h3333_3333, 32'h4444_4444, 4'b1010,
          32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 1'b1, 1'b0, 1'b0);
    // Divide by zero.
    do_op("div", 1'b0, 2'b11, 32'h3F80_0000, 32'h0000_0000,
          32'h5555_5555, 32'h6666_6666, 32'h7F80_0000, 4'b0011,
          32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b1, 1'b0);
    // Multiply with dz still high: no divide-by-zero reported.
    do_op("mul_dz", 1'b1, 2'b10, 32'h3F80_0000, 32'h0000_0000,
          32'h5555_5555, 32'h0000_0000, 32'h7F80_0000, 4'b0011,
          32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    // Multiply with smaller a exponent: never swapped; other req toggles while busy.
    do_op("mul_poke", 1'b0, 2'b10, 32'h3F80_0000, 32'h4040_0000,
          32'h0, 32'h4040_0000, 32'h0, 4'b0100,
          32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 1'b1, 1'b0, 1'b1);
    // Add with equal exponents: no swap.
    do_op("add_eq", 1'b1, 2'b00, 32'h3F80_0000, 32'h3FC0_0000,
          32'h4020_0000, 32'h0, 32'h0, 4'b0000,
          32'h3F80_0000, 32'h3FC0_0000, 32'h4020_0000, 1'b0, 1'b0, 1'b0);

    // Abort mid-operation at dp_cnt == 30.
    start_req(1'b0, 2'b00, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h0, 32'h0, 4'b0000);
    k = 0;
    do begin @(negedge CLK_1MHz); k++; end while (dp_cnt != 6'd30 && k < L + 10);
    chk("abort_reach30", {26'd0, dp_cnt}, 32'd30);
    req0 = 1'b0;
    #2 RSTN = 1'b0;
    #1 check_reset_vals("abort");
    repeat (2) @(negedge CLK_1MHz);
    RSTN = 1'b1;
    cnt = 0;
    repeat (L + 5) begin
      @(negedge CLK_1MHz);
      if (rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 32'd0);
    do_op("after_abort", 1'b0, 2'b00, 32'h4000_0000, 32'h3F80_0000,
          32'h4040_0000, 32'h0, 32'h0, 4'b0000,
          32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);

    // Tie held from reset: grants alternate 0, 1, 0.
    @(negedge CLK_1MHz);
    #2 RSTN = 1'b0;
    op0 = 2'b00; a0 = 32'h3F80_0000; b0 = 32'h3F80_0000;
    op1 = 2'b10; a1 = 32'h4000_0000; b1 = 32'h4000_0000;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge CLK_1MHz);
    RSTN = 1'b1;
    g[0] = 2; g[1] = 2; g[2] = 2;
    n = 0; k = 0;
    while (n < 3 && k < 4 * (L + 3)) begin
      @(negedge CLK_1MHz); k++;
      if (gnt0) begin g[n] = 0; n++; end
      else if (gnt1) begin g[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_count", n, 32'd3);
    chk("tie_g0", g[0], 32'd0);
    chk("tie_g1", g[1], 32'd1);
    chk("tie_g2", g[2], 32'd0);
    k = 0;
    while (busy && k < L + 10) begin @(negedge CLK_1MHz); k++; end
    chk("tie_drain", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge CLK_1MHz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
